// File: rtl/karatsuba_lower_seq.sv
// Sequential lower-half Karatsuba-complement multiplier: r = (A*B) mod 2^N from limb products with i+j<k.
// Build option: KARATSUBA_LOWER_DUAL_MUL_EN issues two scheduled limb products per cycle.
module karatsuba_lower_seq #(
  parameter int N = 64,
  parameter int k = 4,
  parameter int m = N / k
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] r,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // MUL   | one (or two) limb products accumulated per edge
  // DONE  | result presented until out_ready
  localparam int SW = (k > 1) ? $clog2(k) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  a_q, b_q, acc, r_q;
  logic [SW-1:0] s_q, i_q, s_nxt, i_nxt;
  logic [N-1:0]  term_sum, acc_sum;
  logic          last_pair;

  function automatic logic [N-1:0] pair_term(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [SW-1:0] s, input logic [SW-1:0] i);
    logic [SW-1:0]  j;
    logic [m-1:0]   al, bl;
    logic [2*m-1:0] p;
    j  = s - i;
    al = a[m*i +: m];
    bl = b[m*j +: m];
    p  = al * bl;
    return N'(p) << (m*s);
  endfunction

  function automatic logic is_last(input logic [SW-1:0] s, input logic [SW-1:0] i);
    return (s == SW'(k-1)) && (i == SW'(k-1));
  endfunction

  // Schedule order: s ascending, i from 0 up to s
  function automatic logic [2*SW-1:0] adv(input logic [SW-1:0] s, input logic [SW-1:0] i);
    if (i == s) return {s + SW'(1), SW'(0)};
    else        return {s, i + SW'(1)};
  endfunction

`ifdef KARATSUBA_LOWER_DUAL_MUL_EN
  logic [SW-1:0] s2, i2;
  logic          second_ok;

  always_comb begin
    {s2, i2}       = adv(s_q, i_q);
    second_ok      = !is_last(s_q, i_q);
    term_sum       = pair_term(a_q, b_q, s_q, i_q) +
                     (second_ok ? pair_term(a_q, b_q, s2, i2) : '0);
    last_pair      = !second_ok || is_last(s2, i2);
    {s_nxt, i_nxt} = adv(s2, i2);
  end
`else
  always_comb begin
    term_sum       = pair_term(a_q, b_q, s_q, i_q);
    last_pair      = is_last(s_q, i_q);
    {s_nxt, i_nxt} = adv(s_q, i_q);
  end
`endif

  assign acc_sum = acc + term_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = MUL;
      end
      MUL:  if (last_pair) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      r_q <= '0;
      s_q <= '0;
      i_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= A;
          b_q <= B;
          acc <= '0;
          s_q <= '0;
          i_q <= '0;
        end
        MUL: begin
          acc <= acc_sum;
          s_q <= s_nxt;
          i_q <= i_nxt;
          // r only changes when a new result is complete
          if (last_pair) r_q <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign r = r_q;

endmodule

// File: tb/tb_karatsuba_lower_seq.sv
// Scoreboard bench for karatsuba_lower_seq: reference is the plain 2N-bit product truncated to N bits.
module tb_karatsuba_lower_seq;
  localparam int N = 64;
`ifdef KARATSUBA_LOWER_DUAL_MUL_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 10;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         in_ready, out_valid, busy;
  logic [N-1:0] r;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [N-1:0] exp_q[$];
  int           acc_q[$];
  bit           rand_ready = 0;
  bit           prev_valid = 0;
  bit           prev_hold = 0;
  logic [N-1:0] prev_r = '0;

  karatsuba_lower_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .r(r), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [N-1:0] ref_lower(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] full;
    full = (2*N)'(a) * (2*N)'(b);
    return full[N-1:0];
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency, hold stability and result scoreboard
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_valid = 0;
      prev_hold  = 0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", N'(out_valid), N'(1));
        check("hold_r", r, prev_r);
      end
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: out_valid=1 with no accepted operation");
        end else check("latency", N'(cyc - acc_q.pop_front()), N'(LAT));
      end
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: r=%h with empty scoreboard", r);
        end else check("result", r, exp_q.pop_front());
      end
      prev_valid = out_valid;
      prev_hold  = out_valid && !out_ready;
      prev_r     = r;
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready=%0b expected 1", in_ready);
    end else begin
      A = a;
      B = b;
      in_valid = 1'b1;
      exp_q.push_back(ref_lower(a, b));
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out();
    int t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_timeout: out_valid=%0b expected 1", out_valid);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    #3;
    check("rst_in_ready", N'(in_ready), N'(1));
    check("rst_out_valid", N'(out_valid), N'(0));
    check("rst_busy", N'(busy), N'(0));
    check("rst_r", r, N'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    check("dir_all_ones", r, 64'h0000_0000_0000_0001);
    issue(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000);
    drain();
    check("dir_full_wrap", r, 64'h0);
    issue(64'h0001_0002_0003_0004, 64'h1);
    drain();
    check("dir_times_one", r, 64'h0001_0002_0003_0004);

    // Backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    issue({$urandom(), $urandom()}, {$urandom(), $urandom()});
    for (int i = 0; i < 3; i++) begin
      check("mul_busy", N'(busy), N'(1));
      check("mul_in_ready", N'(in_ready), N'(0));
      A = {$urandom(), $urandom()};
      B = {$urandom(), $urandom()};
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_out();
    for (int i = 0; i < 7; i++) begin
      in_valid = i[0];
      A = {$urandom(), $urandom()};
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", N'(in_ready), N'(1));
    check("release_out_valid", N'(out_valid), N'(0));
    check("release_busy", N'(busy), N'(0));
    drain();

    // Reset during the fourth MUL cycle
    issue({$urandom(), $urandom()}, {$urandom(), $urandom()});
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("midrst_r", r, N'(0));
    check("midrst_out_valid", N'(out_valid), N'(0));
    check("midrst_busy", N'(busy), N'(0));
    check("midrst_in_ready", N'(in_ready), N'(1));
    @(negedge clk);
    rst_n = 1'b1;
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    drain();

    rand_ready = 1;
    for (int n = 0; n < 1000; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? '1 : {$urandom(), $urandom()};
      rb = ($urandom_range(0, 7) == 0) ? '1 : {$urandom(), $urandom()};
      issue(ra, rb);
    end
    drain();
    rand_ready = 0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
